io_mmu_arb: RTL



---
 rtl/io_mmu_arb.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/io_mmu_arb.sv
// io_mmu_arb: round-robin arbiter/sequencer sharing one IO-MMU translation
// port among NUM_REQ requesters. One translation in flight at a time; the
// lookup is held across TLB misses, the late permission result is folded
// in, and a watchdog forces a fault after TIMEOUT lookup cycles.
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   req_val_i/vaddr/store per-requester request (held until req_rdy_o)
//   req_rdy_o             one-hot accept pulse (IDLE only)
//   res_*                 one-cycle response: id, paddr, fault, watchdog flag
//   busy_o                translation in progress
//   mmu_*                 translation port to/from the IO-MMU
module io_mmu_arb #(
  parameter int NUM_REQ = 2,
  parameter int VADDR   = 64,
  parameter int PADDR   = 40,
  parameter int TIMEOUT = 1024
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [NUM_REQ-1:0]         req_val_i,
  input  logic [NUM_REQ*VADDR-1:0]   req_vaddr_i,
  input  logic [NUM_REQ-1:0]         req_store_i,
  output logic [NUM_REQ-1:0]         req_rdy_o,
  output logic                       res_val_o,
  output logic [$clog2(NUM_REQ)-1:0] res_id_o,
  output logic [PADDR-1:0]           res_paddr_o,
  output logic                       res_exc_o,
  output logic                       res_timeout_o,
  output logic                       busy_o,
  output logic                       mmu_req_o,
  output logic [VADDR-1:0]           mmu_vaddr_o,
  output logic                       mmu_store_o,
  input  logic                       mmu_hit_i,
  input  logic [PADDR-1:0]           mmu_paddr_i,
  input  logic                       mmu_exc_val_i
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, LOOKUP, CHECK, RESP} state_t;
  state_t state_q, state_d;

  logic [IW-1:0]      ptr_q, id_q, gnt, idx;
  logic [NUM_REQ-1:0] gnt_oh;
  logic               found, gnt_store, store_q, exc_q, to_q;
  logic [VADDR-1:0]   gnt_vaddr, vaddr_q;
  logic [PADDR-1:0]   paddr_q;
  logic [CW-1:0]      cnt_q;

  // Round-robin pick: first requester set, searching from ptr+1 upward.
  always_comb begin
    found  = 1'b0;
    gnt    = '0;
    gnt_oh = '0;
    idx    = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = IW'((int'(ptr_q) + i) % NUM_REQ);
      if (!found && req_val_i[idx]) begin
        found       = 1'b1;
        gnt         = idx;
        gnt_oh[idx] = 1'b1;
      end
    end
    gnt_vaddr = '0;
    gnt_store = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (gnt_oh[k]) begin
        gnt_vaddr = req_vaddr_i[k*VADDR +: VADDR];
        gnt_store = req_store_i[k];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    req_rdy_o = '0;
    mmu_req_o = 1'b0;
    res_val_o = 1'b0;
    busy_o    = (state_q != IDLE);
    case (state_q)
      IDLE: begin
        // No accept while reset is asserted: the grant would be discarded.
        if (found && !rst_i) begin
          req_rdy_o = gnt_oh;
          state_d   = LOOKUP;
        end
      end
      LOOKUP: begin
        mmu_req_o = 1'b1;
        if (mmu_hit_i)                             state_d = CHECK;
        else if (mmu_exc_val_i || cnt_q == CNT_LAST) state_d = RESP;
      end
      CHECK:   state_d = RESP;
      default: begin
        res_val_o = 1'b1;
        state_d   = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q   <= IW'(NUM_REQ - 1);
      id_q    <= '0;
      vaddr_q <= '0;
      store_q <= 1'b0;
      paddr_q <= '0;
      cnt_q   <= '0;
      exc_q   <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (found) begin
          ptr_q   <= gnt;
          id_q    <= gnt;
          vaddr_q <= gnt_vaddr;
          store_q <= gnt_store;
          cnt_q   <= '0;
          exc_q   <= 1'b0;
          to_q    <= 1'b0;
        end
        LOOKUP: begin
          // Hit outranks a same-cycle exception; CHECK re-samples it.
          if (mmu_hit_i)          paddr_q <= mmu_paddr_i;
          else if (mmu_exc_val_i) exc_q   <= 1'b1;
          else if (cnt_q == CNT_LAST) begin
            exc_q <= 1'b1;
            to_q  <= 1'b1;
          end else cnt_q <= cnt_q + CW'(1);
        end
        CHECK:   exc_q <= mmu_exc_val_i;
        default: ;
      endcase
    end
  end

  assign res_id_o      = id_q;
  assign res_paddr_o   = paddr_q;
  assign res_exc_o     = exc_q;
  assign res_timeout_o = to_q;
  assign mmu_vaddr_o   = vaddr_q;
  assign mmu_store_o   = store_q;
endmodule
